h264invtransform: RTL
=====================

Name: h264invtransform

Overview:
- Inverse 4x4 H.264 core transform for the encoder reconstruction loop; the counterpart of the forward core transform.
- Accepts 16 dequantised coefficients per block in zigzag order, one per cycle.
- Outputs reconstructed residual rows, 4 x 9-bit signed per cycle, in the same row packing the forward transform consumes (first pixel in LSBs).
- Sits between the dequantiser and the reconstruction adder.

Parameters:
- IW, 16, input coefficient width (signed).
- OW, 9, output residual width (signed, saturated).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READY  out  1  high when a coefficient may be presented.
- ENABLE  in  1  coefficient strobe; WIN accepted when ENABLE && READY.
- WIN  in  IW  signed dequantised coefficient, zigzag order.
- VALID  out  1  XOUT/ROWOUT valid this cycle.
- XOUT  out  4*OW  residual row; pixel col0 in [OW-1:0] … col3 in [4*OW-1:3*OW].
- ROWOUT  out  2  row index (0..3) of XOUT.

Behaviour:
- Reset (RESET=0, async): READY=0, VALID=0, XOUT=0, ROWOUT=0, load counter=0, state=IDLE. Internal matrices need not clear. READY rises on the first clock edge after RESET deasserts.
- Zigzag position k → (row,col):
  - 0:(0,0) 1:(0,1) 2:(1,0) 3:(2,0)
  - 4:(1,1) 5:(0,2) 6:(0,3) 7:(1,2)
  - 8:(2,1) 9:(3,0) 10:(3,1) 11:(2,2)
  - 12:(1,3) 13:(2,3) 14:(3,2) 15:(3,3)
- Load:
  - 4-bit counter kc increments per accepted coefficient; WIN is written to coefficient buffer C[row][col].
  - On the accept with kc=15: C (including this 16th value) is copied into work matrix W in the same edge, kc wraps to 0, and the transform FSM starts.
  - ENABLE gaps are allowed; the counter holds.
- Transform FSM states: IDLE, ROW0..ROW3, COL0..COL3, then back to IDLE.
  - ROWr (one cycle each) applies the 1-D inverse to W row r and stores the result in H row r.
  - Per 1-D inverse on d0..d3: e0=d0+d2, e1=d0-d2, e2=(d1>>>1)-d3, e3=d1+(d3>>>1); f0=e0+e3, f1=e1+e2, f2=e1-e2, f3=e0-e3.
  - COLr (one cycle each) applies the same 1-D inverse down every column of H and takes element r of each column. Each element is computed as (x+32)>>>6 (arithmetic), then saturated to [-256,255]. XOUT, ROWOUT=r and VALID=1 are registered.
  - VALID=0 in all other states.
- Widths:
  - Row stage: sign-extend to IW+2 = 18 bits.
  - Column stage: sign-extend to 20 bits.
  - No internal overflow for any IW=16 input.
- Latency:
  - The 16th coefficient is accepted at edge T.
  - XOUT row0..row3 are registered at edges T+5..T+8, so VALID is high for 4 consecutive cycles.
- Ping-pong: C is free immediately after the copy to W, so the next block loads with no gap. READY stays 1 after reset.
  - 16 load cycles ≥ 8 transform cycles, so W is never overwritten mid-transform.
  - The next block's 16th coefficient, arriving at the earliest at T+16, finds the FSM in IDLE.
- Simultaneous events: a coefficient accept during ROW/COL states is legal and does not disturb the transform in progress.
- Reset mid-operation:
  - Aborts the transform with no further VALID pulses.
  - Discards the partial load, so the next block starts at zigzag position 0.

Test Plan:
- DC block: k0=640, others 0 → 4 VALID cycles, every pixel=10, ROWOUT=0,1,2,3, first VALID row at T+5.
- Single AC: k1 (row0,col1)=64, others 0 → every row XOUT cols {1,1,0,-1}.
- Saturation: k0=32767 → all pixels 255; k0=-32768 → all pixels -256.
- Back-to-back: blocks A (k0=640) and B (k0=-640) with ENABLE continuously high for 32 cycles → 4 rows of 10, then 4 rows of -10, 8 VALID total, READY never drops.
- Gapped input: ENABLE toggled 1/0 across 16 accepts of a random block → output matches the golden model; latency measured from the 16th accept is exactly 5..8.
- Reset mid-block: assert RESET after 9 accepts (or during COL1) → VALID=0 immediately. After release, a fresh 16-coefficient block produces correct output with no residue from the aborted one.

Source files
------------

// File: rtl/h264invtransform.sv
// Inverse 4x4 H.264 core transform for the encoder reconstruction loop.
// Coefficients arrive in zigzag order, one per accept. On the 16th accept
// the block is copied to a work matrix, which frees the load buffer for the
// next block. Four row passes and four column passes follow, one per cycle.
// Each column pass produces one rounded, saturated residual row.
module h264invtransform #(
  parameter int IW = 16,
  parameter int OW = 9
) (
  input  logic                 CLK,
  input  logic                 RESET,
  output logic                 READY,
  input  logic                 ENABLE,
  input  logic signed [IW-1:0] WIN,
  output logic                 VALID,
  output logic [4*OW-1:0]      XOUT,
  output logic [1:0]           ROWOUT
);

  localparam int RW = IW + 2;  // row-stage width
  localparam int CW = IW + 4;  // column-stage width
  localparam logic signed [CW-1:0] PMAX = CW'((1 << (OW - 1)) - 1);
  localparam logic signed [CW-1:0] PMIN = ~PMAX;
  localparam logic signed [CW-1:0] RND  = CW'(32);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_ROW0 = 4'd1;
  localparam logic [3:0] S_ROW1 = 4'd2;
  localparam logic [3:0] S_ROW2 = 4'd3;
  localparam logic [3:0] S_ROW3 = 4'd4;
  localparam logic [3:0] S_COL0 = 4'd5;
  localparam logic [3:0] S_COL1 = 4'd6;
  localparam logic [3:0] S_COL2 = 4'd7;
  localparam logic [3:0] S_COL3 = 4'd8;

  // 1-D inverse butterfly; result packed {f3,f2,f1,f0}
  function automatic logic [4*CW-1:0] idct4(input logic signed [CW-1:0] d0,
                                            input logic signed [CW-1:0] d1,
                                            input logic signed [CW-1:0] d2,
                                            input logic signed [CW-1:0] d3);
    logic signed [CW-1:0] e0, e1, e2, e3;
    e0 = d0 + d2;
    e1 = d0 - d2;
    e2 = (d1 >>> 1) - d3;
    e3 = d1 + (d3 >>> 1);
    return {e0 - e3, e1 - e2, e1 + e2, e0 + e3};
  endfunction

  // zigzag index to {row,col}
  function automatic logic [3:0] zz_pos(input logic [3:0] k);
    logic [3:0] p;
    case (k)
      4'd0:    p = {2'd0, 2'd0};
      4'd1:    p = {2'd0, 2'd1};
      4'd2:    p = {2'd1, 2'd0};
      4'd3:    p = {2'd2, 2'd0};
      4'd4:    p = {2'd1, 2'd1};
      4'd5:    p = {2'd0, 2'd2};
      4'd6:    p = {2'd0, 2'd3};
      4'd7:    p = {2'd1, 2'd2};
      4'd8:    p = {2'd2, 2'd1};
      4'd9:    p = {2'd3, 2'd0};
      4'd10:   p = {2'd3, 2'd1};
      4'd11:   p = {2'd2, 2'd2};
      4'd12:   p = {2'd1, 2'd3};
      4'd13:   p = {2'd2, 2'd3};
      4'd14:   p = {2'd3, 2'd2};
      4'd15:   p = {2'd3, 2'd3};
      default: p = 4'd0;
    endcase
    return p;
  endfunction

  logic                 r_ready;
  logic [3:0]           r_kc;
  logic [3:0]           r_state;
  logic [3:0]           w_state_nxt;
  logic                 r_valid;
  logic [4*OW-1:0]      r_xout;
  logic [1:0]           r_rowout;
  logic signed [IW-1:0] r_c [4][4];
  logic signed [IW-1:0] r_w [4][4];
  logic signed [RW-1:0] r_h [4][4];

  logic                 w_accept;
  logic                 w_last;
  logic [3:0]           w_zz;
  logic [1:0]           w_zr;
  logic [1:0]           w_zc;
  logic                 w_row_en;
  logic                 w_col_en;
  logic [1:0]           w_ridx;
  logic [1:0]           w_cidx;
  logic [4*CW-1:0]      w_rf;
  logic [4*CW-1:0]      w_cf  [4];
  logic signed [CW-1:0] w_sel [4];
  logic signed [CW-1:0] w_rnd [4];
  logic [4*OW-1:0]      w_xout_d;

  assign w_accept = ENABLE && r_ready;
  assign w_last   = w_accept && (r_kc == 4'd15);
  assign w_zz     = zz_pos(r_kc);
  assign w_zr     = w_zz[3:2];
  assign w_zc     = w_zz[1:0];

  // ready flag and zigzag load counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ready <= 1'b0;
      r_kc    <= 4'd0;
    end else begin
      r_ready <= 1'b1;
      if (w_accept) begin
        r_kc <= r_kc + 4'd1;
      end
    end
  end

  // transform state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state: one cycle per row/column pass, started by the 16th accept
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_last) begin
          w_state_nxt = S_ROW0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ROW0, S_ROW1, S_ROW2, S_ROW3,
      S_COL0, S_COL1, S_COL2: w_state_nxt = r_state + 4'd1;
      S_COL3:                 w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // state decode: which pass is active and on which row/column index
  always_comb begin
    w_row_en = 1'b0;
    w_col_en = 1'b0;
    w_ridx   = 2'd0;
    w_cidx   = 2'd0;
    case (r_state)
      S_ROW0, S_ROW1, S_ROW2, S_ROW3: begin
        w_row_en = 1'b1;
        w_ridx   = 2'(r_state - S_ROW0);
      end
      S_COL0, S_COL1, S_COL2, S_COL3: begin
        w_col_en = 1'b1;
        w_cidx   = 2'(r_state - S_COL0);
      end
      default: begin
        w_row_en = 1'b0;
        w_col_en = 1'b0;
      end
    endcase
  end

  // row pass on the selected work-matrix row
  always_comb begin
    w_rf = idct4(CW'(r_w[w_ridx][0]), CW'(r_w[w_ridx][1]),
                 CW'(r_w[w_ridx][2]), CW'(r_w[w_ridx][3]));
  end

  // column pass on every column, pick element w_cidx, round and saturate
  always_comb begin
    w_xout_d = '0;
    for (int c = 0; c < 4; c++) begin
      w_cf[c]  = idct4(CW'(r_h[0][c]), CW'(r_h[1][c]), CW'(r_h[2][c]), CW'(r_h[3][c]));
      w_sel[c] = w_cf[c][int'(w_cidx)*CW +: CW];
      w_rnd[c] = (w_sel[c] + RND) >>> 6;
      if (w_rnd[c] > PMAX) begin
        w_xout_d[c*OW +: OW] = PMAX[OW-1:0];
      end else if (w_rnd[c] < PMIN) begin
        w_xout_d[c*OW +: OW] = PMIN[OW-1:0];
      end else begin
        w_xout_d[c*OW +: OW] = w_rnd[c][OW-1:0];
      end
    end
  end

  // coefficient buffer, work-matrix copy and row-pass results (no reset needed)
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_c[w_zr][w_zc] <= WIN;
    end
    if (w_last) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          r_w[i][j] <= ((2'(i) == w_zr) && (2'(j) == w_zc)) ? WIN : r_c[i][j];
        end
      end
    end
    if (w_row_en) begin
      for (int j = 0; j < 4; j++) begin
        r_h[w_ridx][j] <= RW'(w_rf[j*CW +: CW]);
      end
    end
  end

  // registered residual row outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid  <= 1'b0;
      r_xout   <= '0;
      r_rowout <= 2'd0;
    end else begin
      r_valid <= w_col_en;
      if (w_col_en) begin
        r_xout   <= w_xout_d;
        r_rowout <= w_cidx;
      end
    end
  end

  assign READY  = r_ready;
  assign VALID  = r_valid;
  assign XOUT   = r_xout;
  assign ROWOUT = r_rowout;

endmodule
